// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word memory access with lane alignment, sign extension and exceptions.
// Latency (same-cycle ack): load 2, word store 2, byte/half store 3 (read-modify-write), exception 1.
// Backpressure: req_ready only in IDLE; strobes held until mem_ack or TIMEOUT wait cycles expire.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic [ADDR_W-1:0] exc_addr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q, signed_q;
  logic [1:0]        size_q, exc_q, exc_nxt, chk;
  logic [31:0]       data_q, data_nxt, merged, load_res;
  logic [7:0]        cnt_q, cnt_nxt;
  logic              accept;

  assign accept = req_valid && req_ready;

  // Accept-time fault check; illegal size outranks misalignment.
  always_comb begin
    chk = 2'b00;
    if (req_size == 2'b11)
      chk = 2'b10;
    else if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      chk = 2'b01;
  end

  // Lane merge for sub-word stores: data_q still holds the store data while READ is pending.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  // Load result extraction from the registered read word.
  always_comb begin
    load_res = data_q;
    case (size_q)
      2'b00: load_res = {{24{signed_q & data_q[{addr_q[1:0], 3'b111}]}}, data_q[{addr_q[1:0], 3'b000} +: 8]};
      2'b01: load_res = {{16{signed_q & data_q[{addr_q[1], 4'b1111}]}}, data_q[{addr_q[1], 4'b0000} +: 16]};
      default: load_res = data_q;
    endcase
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_nxt = state;
    exc_nxt   = exc_q;
    data_nxt  = data_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt  = 8'd0;
          data_nxt = req_wdata;
          exc_nxt  = chk;
          if (chk != 2'b00)
            state_nxt = RESP;
          else if (req_write && req_size == 2'b10)
            state_nxt = WRITE;
          else
            state_nxt = READ;
        end
      end
      READ: begin
        if (mem_ack) begin
          cnt_nxt = 8'd0;
          if (write_q) begin
            data_nxt  = merged;
            state_nxt = WRITE;
          end else begin
            data_nxt  = mem_rdata;
            state_nxt = RESP;
          end
        end else if (cnt_q + 8'd1 == TO) begin
          exc_nxt   = 2'b11;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_nxt = RESP;
        end else if (cnt_q + 8'd1 == TO) begin
          exc_nxt   = 2'b11;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_nxt   = 8'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and request capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      exc_q    <= 2'b00;
      data_q   <= 32'd0;
      cnt_q    <= 8'd0;
    end else begin
      state  <= state_nxt;
      exc_q  <= exc_nxt;
      data_q <= data_nxt;
      cnt_q  <= cnt_nxt;
      if (accept) begin
        addr_q   <= req_addr;
        write_q  <= req_write;
        signed_q <= req_signed;
        size_q   <= req_size;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_rd    = (state == READ);
  assign mem_wr    = (state == WRITE);
  assign mem_addr  = (mem_rd || mem_wr) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_wr ? data_q : 32'd0;
  assign rsp_valid = (state == RESP);
  assign exc_valid = rsp_valid && (exc_q != 2'b00);
  assign exc_code  = rsp_valid ? exc_q : 2'b00;
  assign exc_addr  = exc_valid ? addr_q : '0;
  assign rsp_data  = (rsp_valid && !write_q && exc_q == 2'b00) ? load_res : 32'd0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width (>=3).
REQ-002 Parameter TIMEOUT, default 15, max cycles waited for mem_ack per memory access (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; clears all state immediately while low.
REQ-005 req_valid / req_ready  input/output  1/1  request handshake; transfer when both high on a clock edge.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 mem_addr  output  ADDR_W  word address, {req_addr[ADDR_W-1:2],2'b00}.
REQ-012 mem_rd / mem_wr  output  1/1  memory read/write strobes, held high until mem_ack.
REQ-013 mem_wdata  output  32  full word written to memory.
REQ-014 mem_rdata / mem_ack  input  32/1  read data and access-complete pulse.
REQ-015 rsp_valid  output  1  one-cycle pulse: operation finished (success or exception).
REQ-016 rsp_data  output  32  load result; 0 for stores and exceptions.
REQ-017 exc_valid / exc_code  output  1/2  exception flag; code 01 misaligned, 10 illegal size, 11 memory timeout.
REQ-018 exc_addr  output  ADDR_W  faulting req_addr, valid with exc_valid.

Function
REQ-019 States: IDLE, READ, WRITE, RESP; req_ready high only in IDLE.
REQ-020 All request fields are captured into registers on the accepting edge; inputs are ignored afterwards.
REQ-021 Accept-time check, priority illegal size over misalignment: size 11 -> code 10; half with addr[0]=1 or word with addr[1:0]!=0 -> code 01; go directly to RESP, no memory strobe.
REQ-022 Lanes little-endian: byte k = data[8k+7:8k], k = addr[1:0]; half at addr[1]=h = data[16h+15:16h].
REQ-023 Load (any size): IDLE -> READ; on mem_ack register mem_rdata and go to RESP.
REQ-024 Load result: selected lane right-justified, upper bits = lane MSB if req_signed else 0; word passes unchanged.
REQ-025 Word store: IDLE -> WRITE with mem_wdata = req_wdata.
REQ-026 Byte/half store (read-modify-write): IDLE -> READ; on mem_ack -> WRITE with mem_wdata = mem_rdata with only the target lane replaced by req_wdata low bits.
REQ-027 WRITE -> RESP on mem_ack.
REQ-028 RESP lasts exactly one cycle: rsp_valid=1, exc outputs asserted if faulted, then IDLE.
REQ-029 Latency with same-cycle ack: load 2 cycles accept-to-rsp_valid, word store 2, byte/half store 3, exception 1.
REQ-030 Timeout counter reset on entering READ/WRITE, incremented each cycle without mem_ack; reaching TIMEOUT -> drop strobes, RESP with code 11.
REQ-031 mem_ack in IDLE or RESP is ignored; mem_rd and mem_wr are never high together.
REQ-032 Outputs rsp_data, exc_valid, exc_code, exc_addr are 0 whenever rsp_valid=0.

Reset
REQ-033 While reset=0: state IDLE, req_ready=1, mem_rd=mem_wr=0, mem_addr=mem_wdata=0, rsp_valid=0, rsp_data=0, exc_valid=0, exc_code=00, exc_addr=0, counter 0.
REQ-034 Reset asserted mid-operation aborts it with no response; first cycle after release is IDLE.

Verification
REQ-035 Load byte, addr 0x103, signed, mem_rdata 0x80112233 -> mem_addr 0x100, rsp_data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Store half, addr 0x202, wdata 0xABCD, read returns 0x11223344 -> mem_wr with mem_wdata 0xABCD3344, rsp_valid, no exception.
REQ-037 Load word addr 0x06 -> no strobe, rsp_valid next cycle, exc code 01, exc_addr 0x06; size 11 at 0x06 -> code 10.
REQ-038 Load with mem_ack held low, TIMEOUT=15 -> mem_rd dropped, rsp_valid with code 11 after 15 wait cycles.
REQ-039 Back-to-back word loads with same-cycle ack -> req_ready re-asserts cycle after rsp_valid, two correct responses.
REQ-040 reset pulled low during WRITE -> mem_wr falls immediately, no rsp_valid, IDLE after release.
